// File: rtl/axis_frame_packer_if.sv
// AXI-Stream output bundle for axis_frame_packer.
// Ports: tdata/tkeep/tlast/tvalid from master, tready from slave.
interface axis_frame_packer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_frame_packer.sv
// Packs a non-stallable sample stream into fixed-length AXI-Stream frames.
// Ports: clk, rst (async high), enable, frame_len, s_data/s_valid in;
// m_axis (master stream), busy, overflow, drop_cnt, frame_cnt out.
module axis_frame_packer #(
  parameter int               DATA_W     = 32,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] PAD_WORD  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [15:0]          frame_len,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_valid,
  axis_frame_packer_if.master  m_axis,
  output logic                 busy,
  output logic                 overflow,
  output logic [31:0]          drop_cnt,
  output logic [31:0]          frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state, state_n;
  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [15:0]         beat_cnt, len_q, len_start;
  logic                empty, full, pop, room, is_last;
  logic                wr_en, drop;
  logic [DATA_W-1:0]   wr_word;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = !empty && m_axis.tready;
  // a full FIFO still accepts a word when the head leaves this cycle
  assign room      = !full || pop;
  assign len_start = (frame_len == 16'd0) ? 16'd1 : frame_len;
  assign is_last   = (beat_cnt == len_q - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable) state_n = RUN;
      RUN:     if (!enable)
                 state_n = (beat_cnt == 16'd0) ? IDLE : FLUSH;
      FLUSH:   if (wr_en && is_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_word = s_data;
    drop    = 1'b0;
    unique case (state)
      RUN: if (enable && s_valid) begin
        wr_en = room;
        drop  = !room;
      end
      FLUSH: begin
        wr_en   = room;
        wr_word = PAD_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      len_q    <= 16'd1;
    end else if (state == IDLE && enable) begin
      beat_cnt <= '0;
      len_q    <= len_start;
    end else if (wr_en) begin
      if (is_last) begin
        beat_cnt <= '0;
        len_q    <= len_start;
      end else begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {is_last, wr_word};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
      end
      if (pop && m_axis.tlast) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  // head is gated so the bus reads zero while nothing is queued
  assign m_axis.tvalid = !empty;
  assign {m_axis.tlast, m_axis.tdata} = empty ? '0 : mem[rd_ptr];
  assign m_axis.tkeep  = '1;
  assign busy          = (state != IDLE) || !empty;
endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer: directed scenarios plus random traffic.
// A frame-level reference model predicts beats; a monitor checks every handshake.
module tb_axis_frame_packer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_FLUSH} mmode_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [15:0]   frame_len = 16'd4;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          busy, overflow;
  logic [31:0]   drop_cnt, frame_cnt;

  axis_frame_packer_if #(.DATA_W(DW)) m_axis ();

  axis_frame_packer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PAD_WORD('0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_len(frame_len),
    .s_data(s_data), .s_valid(s_valid), .m_axis(m_axis),
    .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   exp_q[$];
  mmode_t mmode = M_IDLE;
  int     mcount = 0, mbeat = 0, mlen = 1;
  longint mdrop = 0;
  bit     movf = 0;
  int     mframes = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int eff_len(input logic [15:0] l);
    return (l == 16'd0) ? 1 : int'(l);
  endfunction

  // Frame rules: every accepted word belongs to a frame of exactly mlen beats.
  task automatic model_write(input logic [DW-1:0] d);
    bit last;
    last = (mbeat == mlen - 1);
    exp_q.push_back('{d, last});
    mcount++;
    if (last) begin
      mbeat = 0;
      mlen  = eff_len(frame_len);
      if (mmode == M_FLUSH) mmode = M_IDLE;
    end else begin
      mbeat++;
    end
  endtask

  task automatic model_step();
    bit pop, room;
    if (rst) begin
      mmode = M_IDLE; mcount = 0; mbeat = 0; mlen = 1;
      mdrop = 0; movf = 0; exp_q.delete();
      return;
    end
    pop  = (mcount > 0) && m_axis.tready;
    room = (mcount < DEPTH) || pop;
    if (pop) mcount--;
    case (mmode)
      M_IDLE: if (enable) begin
        mmode = M_RUN; mbeat = 0; mlen = eff_len(frame_len);
      end
      M_RUN: begin
        if (!enable) mmode = (mbeat == 0) ? M_IDLE : M_FLUSH;
        else if (s_valid) begin
          if (room) model_write(s_data);
          else begin
            if (mdrop < 64'hFFFF_FFFF) mdrop++;
            movf = 1;
          end
        end
      end
      M_FLUSH: if (room) model_write('0);
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      mframes = 0;
      chk("tvalid_in_reset", 64'(m_axis.tvalid), 64'd0);
    end else begin
      chk("tvalid", 64'(m_axis.tvalid), 64'(mcount != 0));
      chk("busy", 64'(busy), 64'((mmode != M_IDLE) || (mcount != 0)));
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("frame_cnt", 64'(frame_cnt), 64'(mframes));
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis.tdata), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(m_axis.tdata), 64'(e.d));
          chk("tlast", 64'(m_axis.tlast), 64'(e.last));
          if (e.last) mframes++;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [15:0] len, input logic rdy);
    frame_len = len; m_axis.tready = rdy; enable = 1'b1; s_valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = first + DW'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    m_axis.tready = 1'b0;
    #1;
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tkeep", 64'(m_axis.tkeep), 64'hF);
    tick();
    rst = 1'b0;

    // frame_len 4, continuous samples 1..8
    start(16'd4, 1'b1);
    send(32'd1, 8);
    tick(4);
    chk("t1_frames", 64'(frame_cnt), 64'd2);
    enable = 1'b0; tick(2);

    // backpressure overflow: 20 samples into 16 entries
    do_reset();
    start(16'd8, 1'b0);
    send(32'd100, 20);
    chk("t3_drops", 64'(drop_cnt), 64'd4);
    chk("t3_ovf", 64'(overflow), 64'd1);
    m_axis.tready = 1'b1;
    tick(20);
    chk("t3_frames", 64'(frame_cnt), 64'd2);
    enable = 1'b0; tick(2);

    // flush padding after a short partial frame
    do_reset();
    start(16'd5, 1'b1);
    send(32'd10, 3);
    enable = 1'b0; s_valid = 1'b1; s_data = 32'd99;
    tick();
    s_valid = 1'b0;
    tick(10);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_frames", 64'(frame_cnt), 64'd1);

    // frame_len 0 -> single-beat frames
    do_reset();
    start(16'd0, 1'b1);
    send(32'd50, 6);
    tick(3);
    chk("t5_frames", 64'(frame_cnt), 64'd6);
    enable = 1'b0; tick(2);

    // reset mid-frame with six queued entries and a nonzero frame count
    start(16'd8, 1'b0);
    send(32'd200, 6);
    rst = 1'b1; enable = 1'b0;
    #1;
    chk("t6_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("t6_frames", 64'(frame_cnt), 64'd0);
    chk("t6_drops", 64'(drop_cnt), 64'd0);
    tick();
    rst = 1'b0;
    start(16'd4, 1'b1);
    send(32'd300, 4);
    tick(3);
    chk("t6_reframe", 64'(frame_cnt), 64'd1);
    enable = 1'b0; tick(2);

    // random traffic with enable toggles and changing frame_len
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) frame_len = 16'($urandom_range(0, 7));
      s_valid       = ($urandom_range(0, 3) != 0);
      s_data        = $urandom;
      m_axis.tready = ($urandom_range(0, 9) < 6);
      tick();
    end

    enable = 1'b0; s_valid = 1'b0; m_axis.tready = 1'b1;
    begin
      int w;
      w = 0;
      while ((busy || exp_q.size() != 0) && w < 500) begin
        tick();
        w++;
      end
      chk("drain_timeout", 64'(w < 500), 64'd1);
    end
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
